multi_cycle_ctrl: RTL

Control unit for the multi-cycle MIPS core: the decode/sequencing end of the datapath control interface. It latches each fetched instruction into an internal IR and steps a Moore FSM (FETCH/DECODE/EXE/MEM/WB). It drives the datapath select and write-enable signals, gating every architectural write to exactly one cycle per instruction. It also counts retired instructions for the bench.

---
 rtl/mips_defs.sv | 61 ++++++
 rtl/ctrl_decode.sv | 64 ++++++
 rtl/multi_cycle_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// -----------------------------------------------------------------------------
// mips_defs
// Shared definitions for the multi-cycle MIPS control unit:
//   - opcode / funct field values of the supported instructions
//   - FSM state codes (FETCH=0 .. WB=4)
//   - instruction class produced by the decoder
//   - packed bundle of datapath select signals
// -----------------------------------------------------------------------------
package mips_defs;

  // Opcode field ir[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Funct field ir[5:0] for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // FSM state codes; 5..7 are unused encodings
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Instruction class, drives the FSM path through EXE/MEM/WB
  typedef enum logic [3:0] {
    C_NOP,
    C_ILL,
    C_ADD,
    C_SUB,
    C_JR,
    C_ORI,
    C_LW,
    C_SW,
    C_BEQ,
    C_LUI,
    C_JAL
  } iclass_t;

  // Datapath select bundle (order matches the top-level output grouping)
  typedef struct packed {
    logic add;
    logic cin;
    logic aluop;
    logic lui;
    logic regc;
    logic wd;
    logic bsel;
    logic extop;
  } sel_t;

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational decode of the latched instruction word.
// Ports:
//   ir     in  32  latched instruction
//   iclass out     instruction class (nop / illegal / one per supported op)
//   sel    out     datapath select signals for that instruction
// -----------------------------------------------------------------------------
module ctrl_decode
  import mips_defs::*;
(
  input  logic [31:0] ir,
  output iclass_t     iclass,
  output sel_t        sel
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave a value unassigned and infer a latch.
    iclass = C_ILL;
    sel    = '0;

    // Only the all-zero word is a nop; other funct-0 R-types are illegal.
    if (ir == 32'h0) begin
      iclass = C_NOP;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          case (funct)
            FN_ADD:  iclass = C_ADD;
            FN_SUB:  iclass = C_SUB;
            FN_JR:   iclass = C_JR;
            default: iclass = C_ILL;
          endcase
        end
        OP_ORI:  iclass = C_ORI;
        OP_LW:   iclass = C_LW;
        OP_SW:   iclass = C_SW;
        OP_BEQ:  iclass = C_BEQ;
        OP_LUI:  iclass = C_LUI;
        OP_JAL:  iclass = C_JAL;
        default: iclass = C_ILL;
      endcase
    end

    case (iclass)
      C_ADD: begin sel.regc = 1'b1; sel.add = 1'b1; end
      C_SUB: begin sel.regc = 1'b1; sel.add = 1'b1; sel.cin = 1'b1; end
      C_ORI: begin sel.bsel = 1'b1; sel.aluop = 1'b1; end
      C_LW:  begin sel.bsel = 1'b1; sel.extop = 1'b1; sel.add = 1'b1; sel.wd = 1'b1; end
      C_SW:  begin sel.bsel = 1'b1; sel.extop = 1'b1; sel.add = 1'b1; end
      C_BEQ: begin sel.add = 1'b1; sel.cin = 1'b1; end
      C_LUI: begin sel.bsel = 1'b1; sel.lui = 1'b1; end
      default: sel = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
// Control unit of the multi-cycle MIPS core. Latches the fetched instruction
// into IR, sequences FETCH/DECODE/EXE/MEM/WB as a Moore FSM and raises every
// architectural write enable for exactly one cycle per instruction.
// Ports:
//   clk, reset (async, active low)
//   instr   in  32  instruction memory output for current pc
//   result  in   1  ALU equal flag (consumed directly by the NPC mux)
//   ir_out  out 32  latched instruction
//   pc_we, we, sw   out  PC / GRF / DM write enables
//   add, cin, aluop, lui, RegC, WD, Bsel, EXTop   out  datapath selects
//   beq, jal, jr    out  NPC source selects
//   state   out  3  current FSM state
//   illegal out  1  one-cycle pulse on unsupported encoding
//   retired out CNT_W  instructions completed since reset (wraps)
// -----------------------------------------------------------------------------
module multi_cycle_ctrl
  import mips_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             result,
  output logic [31:0]      ir_out,
  output logic             pc_we,
  output logic             add,
  output logic             cin,
  output logic             aluop,
  output logic             lui,
  output logic             RegC,
  output logic             WD,
  output logic             Bsel,
  output logic             EXTop,
  output logic             beq,
  output logic             jal,
  output logic             jr,
  output logic             we,
  output logic             sw,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] retired_q;

  iclass_t iclass;
  sel_t    dec_sel;
  sel_t    sel_c;
  logic    pc_we_c, we_c, sw_c, ill_c, beq_c, jal_c, jr_c;

  // The branch decision is made by the NPC mux from result and beq; the
  // control FSM is Moore and takes the same path whether or not it is taken.
  logic unused_result;
  assign unused_result = result;

  ctrl_decode u_decode (
    .ir     (ir_q),
    .iclass (iclass),
    .sel    (dec_sel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      state_q <= state_d;
      if (state_q == S_FETCH) ir_q <= instr;
      if (pc_we_c) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = S_FETCH;
    pc_we_c = 1'b0;
    we_c    = 1'b0;
    sw_c    = 1'b0;
    ill_c   = 1'b0;
    beq_c   = 1'b0;
    jal_c   = 1'b0;
    jr_c    = 1'b0;
    sel_c   = '0;

    case (state_q)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        sel_c = dec_sel;
        if (iclass == C_NOP || iclass == C_ILL) begin
          pc_we_c = 1'b1;
          ill_c   = (iclass == C_ILL);
        end else if (iclass == C_JAL) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXE;
        end
      end

      S_EXE: begin
        sel_c = dec_sel;
        case (iclass)
          C_BEQ:      begin pc_we_c = 1'b1; beq_c = 1'b1; end
          C_JR:       begin pc_we_c = 1'b1; jr_c  = 1'b1; end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end

      S_MEM: begin
        sel_c = dec_sel;
        if (iclass == C_SW) begin
          sw_c    = 1'b1;
          pc_we_c = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end

      S_WB: begin
        sel_c   = dec_sel;
        we_c    = 1'b1;
        pc_we_c = 1'b1;
        jal_c   = (iclass == C_JAL);
      end

      // Unused encodings fall back to FETCH with everything deasserted.
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are also qualified by reset so nothing can pulse while it is low,
  // even in the delta before the state register clears.
  assign pc_we   = pc_we_c & reset;
  assign we      = we_c    & reset;
  assign sw      = sw_c    & reset;
  assign illegal = ill_c   & reset;
  assign beq     = beq_c;
  assign jal     = jal_c;
  assign jr      = jr_c;

  assign {add, cin, aluop, lui, RegC, WD, Bsel, EXTop} = sel_c;

  assign ir_out  = ir_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule
